// File: rtl/hwpe_switch_ctrl_pkg.sv
// rtl/hwpe_switch_ctrl_pkg.sv - shared types and limits for the HWPE switch controller
package pulp_cluster_package;

  localparam int HWPE_SW_MAX_HWPES = 8;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_GATE   = 3'd3,
    ST_CLEAR  = 3'd4,
    ST_ENABLE = 3'd5
  } hwpe_switch_state_e;

endpackage

// File: rtl/hwpe_switch_ctrl_outstanding_cnt.sv
// rtl/hwpe_switch_ctrl_outstanding_cnt.sv - in-flight TCDM transaction counter with saturation flags
module hwpe_outstanding_cnt
  import pulp_cluster_package::*;
#(
  parameter int N_PORTS         = 9,
  parameter int MAX_OUTSTANDING = 8,
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic [N_PORTS-1:0] i_req,
  input  logic [N_PORTS-1:0] i_gnt,
  input  logic [N_PORTS-1:0] i_rvalid,
  output logic [CW-1:0]      o_cnt,
  output logic               o_ovf,
  output logic               o_udf
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  int            w_add;
  int            w_sub;
  int            w_sum;

  // Signed sum so a response at zero shows up as a negative result rather than wrapping.
  always_comb begin
    w_add = 0;
    w_sub = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_add = w_add + int'(i_req[i] & i_gnt[i]);
      w_sub = w_sub + int'(i_rvalid[i]);
    end
    w_sum = int'(r_cnt) + w_add - w_sub;
    o_ovf = (w_sum > MAX_OUTSTANDING);
    o_udf = (w_sum < 0);
    if (i_clr || o_udf) begin
      w_cnt_nxt = '0;
    end else if (o_ovf) begin
      w_cnt_nxt = CW'(MAX_OUTSTANDING);
    end else begin
      w_cnt_nxt = CW'(w_sum);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hwpe_switch_ctrl.sv
// rtl/hwpe_switch_ctrl.sv - drain/gate/clear/enable sequencer for switching the active HWPE
// Optional drain watchdog: HWPE_SWITCH_TIMEOUT_EN.
module hwpe_switch_ctrl
  import pulp_cluster_package::*;
#(
  parameter int N_HWPES         = 2,
  parameter int N_PORTS         = 9,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CLEAR_CYCLES    = 2,
`ifdef HWPE_SWITCH_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES  = 1024,
`endif
  localparam int SEL_W          = (N_HWPES > 1) ? $clog2(N_HWPES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               test_mode_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [SEL_W-1:0]   req_sel_i,
  input  logic               req_en_i,
  input  logic [N_HWPES-1:0] hwpe_busy_i,
  input  logic [N_PORTS-1:0] tcdm_req_i,
  input  logic [N_PORTS-1:0] tcdm_gnt_i,
  input  logic [N_PORTS-1:0] tcdm_rvalid_i,
  output logic [N_HWPES-1:0] hwpe_en_o,
  output logic [SEL_W-1:0]   hwpe_sel_o,
  output logic [N_HWPES-1:0] hwpe_clear_o,
  output logic               cfg_block_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int CCW = $clog2(CLEAR_CYCLES + 1);

  hwpe_switch_state_e r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_sel, r_target_sel;
  logic               r_target_en;
  logic [CCW-1:0]     r_clr_cnt;
  logic               r_done, r_err;
  logic [CW-1:0]      w_cnt;
  logic               w_ovf, w_udf, w_timeout;
  logic               w_idle, w_accept, w_same, w_drained;
  logic [N_HWPES-1:0] w_onehot;

  hwpe_outstanding_cnt #(
    .N_PORTS        (N_PORTS),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_timeout),
    .i_req   (tcdm_req_i),
    .i_gnt   (tcdm_gnt_i),
    .i_rvalid(tcdm_rvalid_i),
    .o_cnt   (w_cnt),
    .o_ovf   (w_ovf),
    .o_udf   (w_udf)
  );

`ifdef HWPE_SWITCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;

  assign w_timeout = (r_state == ST_DRAIN) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= ((r_state == ST_DRAIN) && !w_timeout) ? r_to_cnt + 1'b1 : '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_idle    = (r_state == ST_OFF) || (r_state == ST_ACTIVE);
  assign w_accept  = w_idle && req_valid_i;
  assign w_same    = (req_sel_i == r_sel) && (req_en_i == (r_state == ST_ACTIVE));
  assign w_drained = !hwpe_busy_i[r_sel] && (w_cnt == '0);

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < N_HWPES; i++) w_onehot[i] = (r_sel == SEL_W'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_OFF;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OFF, ST_ACTIVE: begin
        // Nothing is clocked while OFF, so there is nothing to drain.
        if (w_accept && !w_same) w_state_nxt = (r_state == ST_OFF) ? ST_GATE : ST_DRAIN;
      end
      ST_DRAIN:  if (w_drained || w_timeout) w_state_nxt = ST_GATE;
      ST_GATE:   w_state_nxt = r_target_en ? ST_CLEAR : ST_OFF;
      ST_CLEAR:  if (r_clr_cnt == CCW'(CLEAR_CYCLES - 1)) w_state_nxt = ST_ENABLE;
      ST_ENABLE: w_state_nxt = ST_ACTIVE;
      default:   w_state_nxt = ST_OFF;
    endcase
  end

  always_comb begin
    req_ready_o  = 1'b0;
    hwpe_en_o    = '0;
    hwpe_clear_o = '0;
    cfg_block_o  = 1'b0;
    case (r_state)
      ST_OFF:    req_ready_o = 1'b1;
      ST_ACTIVE: begin
        req_ready_o = 1'b1;
        hwpe_en_o   = w_onehot;
      end
      ST_DRAIN: begin
        hwpe_en_o   = w_onehot;
        cfg_block_o = 1'b1;
      end
      ST_GATE:   cfg_block_o = 1'b1;
      ST_CLEAR: begin
        hwpe_en_o    = w_onehot;
        hwpe_clear_o = w_onehot;
        cfg_block_o  = 1'b1;
      end
      ST_ENABLE: hwpe_en_o = w_onehot;
      default:   ;
    endcase
    if (test_mode_i) hwpe_en_o = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel        <= '0;
      r_target_sel <= '0;
      r_target_en  <= 1'b0;
      r_clr_cnt    <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (w_same) begin
          r_done <= 1'b1;
        end else begin
          r_target_sel <= req_sel_i;
          r_target_en  <= req_en_i;
        end
      end
      if (r_state == ST_GATE) begin
        r_sel <= r_target_sel;
        if (!r_target_en) r_done <= 1'b1;
      end
      r_clr_cnt <= (r_state == ST_CLEAR) ? r_clr_cnt + 1'b1 : '0;
      if (w_ovf || w_udf || w_timeout) r_err <= 1'b1;
    end
  end

  assign hwpe_sel_o = r_sel;
  assign done_o     = r_done || (r_state == ST_ENABLE);
  assign err_o      = r_err;

endmodule

// File: tb/tb_hwpe_switch_ctrl.sv
// tb/tb_hwpe_switch_ctrl.sv - scoreboard bench for hwpe_switch_ctrl (HWPE_SWITCH_TIMEOUT_EN adds the watchdog case)
module tb_hwpe_switch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       test_mode = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [0:0] req_sel = '0;
  logic       req_en = 1'b0;
  logic [1:0] hwpe_busy = '0;
  logic [8:0] tcdm_req = '0;
  logic [8:0] tcdm_gnt = '0;
  logic [8:0] tcdm_rvalid = '0;
  logic [1:0] hwpe_en;
  logic [0:0] hwpe_sel;
  logic [1:0] hwpe_clear;
  logic       cfg_block;
  logic       done;
  logic       err;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic [0:0] sel;
    logic [1:0] en;
    logic       err;
    int         lat;
    int         t_acc;
    int         clr_cyc;
    logic [1:0] clr_mask;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_x;
  int         acc_c = 0;
  logic [1:0] acc_m = '0;

`ifdef HWPE_SWITCH_TIMEOUT_EN
  `define TB_SW_PARAMS .N_HWPES(2), .N_PORTS(9), .TIMEOUT_CYCLES(16)
`else
  `define TB_SW_PARAMS .N_HWPES(2), .N_PORTS(9)
`endif

  hwpe_switch_ctrl #(`TB_SW_PARAMS) dut (
    .clk          (clk),
    .rst          (rst),
    .test_mode_i  (test_mode),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_sel_i    (req_sel),
    .req_en_i     (req_en),
    .hwpe_busy_i  (hwpe_busy),
    .tcdm_req_i   (tcdm_req),
    .tcdm_gnt_i   (tcdm_gnt),
    .tcdm_rvalid_i(tcdm_rvalid),
    .hwpe_en_o    (hwpe_en),
    .hwpe_sel_o   (hwpe_sel),
    .hwpe_clear_o (hwpe_clear),
    .cfg_block_o  (cfg_block),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_en"}, 32'(hwpe_en), 32'd0);
    check({tag, "_sel"}, 32'(hwpe_sel), 32'd0);
    check({tag, "_clear"}, 32'(hwpe_clear), 32'd0);
    check({tag, "_cfg_block"}, 32'(cfg_block), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic do_req(input logic [0:0] s, input logic e, input logic push, input int lat,
                        input logic [1:0] x_en, input int ccyc, input logic [1:0] cmask,
                        input logic x_err);
    exp_t x;
    bit   ok = 1'b0;
    req_sel   = s;
    req_en    = e;
    req_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("req_ready_wait", 32'(ok), 32'd1);
    if (push) begin
      x.sel = s; x.en = x_en; x.err = x_err; x.lat = lat; x.t_acc = cyc;
      x.clr_cyc = ccyc; x.clr_mask = cmask;
      q.push_back(x);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({name, "_done_wait"}, 32'(ok), 32'd1);
    tick();
  endtask

  // Monitor: every done_o pulse is matched against the oldest expected completion.
  always @(negedge clk) begin
    if (rst) begin
      acc_c = 0;
      acc_m = '0;
    end else begin
      if (hwpe_clear != 2'b00) begin
        acc_c++;
        acc_m = acc_m | hwpe_clear;
      end
      if (done) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: actual done_o=1 required no pending switch (cycle %0d)", cyc);
        end else begin
          mon_x = q.pop_front();
          check("sb_sel", 32'(hwpe_sel), 32'(mon_x.sel));
          check("sb_en", 32'(hwpe_en), 32'(mon_x.en));
          check("sb_err", 32'(err), 32'(mon_x.err));
          check("sb_clear_cycles", 32'(acc_c), 32'(mon_x.clr_cyc));
          check("sb_clear_mask", 32'(acc_m), 32'(mon_x.clr_mask));
          if (mon_x.lat >= 0) check("sb_latency", 32'(cyc - mon_x.t_acc), 32'(mon_x.lat));
        end
        acc_c = 0;
        acc_m = '0;
      end
    end
  end

  initial begin
    #1;
    check_reset_outputs("rst_hold");
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("rst_idle");

    // OFF -> sel 1: no drain, two clear cycles on HWPE 1.
    do_req(1'b1, 1'b1, 1'b1, 4, 2'b10, 2, 2'b10, 1'b0);
    wait_done("off_to_1");

    // Repeat of the current selection completes in one cycle.
    do_req(1'b1, 1'b1, 1'b1, 1, 2'b10, 0, 2'b00, 1'b0);
    wait_done("repeat_1");

    // ACTIVE -> ACTIVE with an idle HWPE.
    do_req(1'b0, 1'b1, 1'b1, 5, 2'b01, 2, 2'b01, 1'b0);
    wait_done("1_to_0");

    // Three grants in flight (one request without grant is not counted).
    tcdm_req = 9'b1_0000_0111;
    tcdm_gnt = 9'b0_1000_0111;
    tick();
    tcdm_req = '0;
    tcdm_gnt = '0;
    do_req(1'b1, 1'b1, 1'b1, -1, 2'b10, 2, 2'b10, 1'b0);
    check("drain_cfg_block", 32'(cfg_block), 32'd1);
    check("drain_en_old", 32'(hwpe_en), 32'b01);
    check("drain_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    check("drain_hold_cnt3", 32'(cfg_block), 32'd1);
    tcdm_rvalid = 9'b0_0000_0011;
    tick();
    tcdm_rvalid = '0;
    tick();
    check("drain_hold_cnt1", 32'(cfg_block), 32'd1);
    hwpe_busy   = 2'b01;
    tcdm_rvalid = 9'b1_0000_0000;
    tick();
    tcdm_rvalid = '0;
    tick();
    check("drain_hold_busy", 32'(cfg_block), 32'd1);
    hwpe_busy = 2'b00;
    wait_done("drain_0_to_1");

    // Grant and response in the same cycle net out; a response at zero flags an error.
    tcdm_req = 9'b0_0000_0001;
    tcdm_gnt = 9'b0_0000_0001;
    tick();
    tcdm_req    = 9'b0_0000_0010;
    tcdm_gnt    = 9'b0_0000_0010;
    tcdm_rvalid = 9'b0_0000_0100;
    tick();
    tcdm_req    = '0;
    tcdm_gnt    = '0;
    tcdm_rvalid = 9'b0_0000_0001;
    tick();
    tcdm_rvalid = '0;
    tick();
    check("net_no_err", 32'(err), 32'd0);
    tcdm_rvalid = 9'b0_0000_1000;
    tick();
    tcdm_rvalid = '0;
    check("underflow_err", 32'(err), 32'd1);
    tick();
    check("err_sticky", 32'(err), 32'd1);

    // Disable from ACTIVE: drain, gate, OFF.
    do_req(1'b1, 1'b0, 1'b1, 3, 2'b00, 0, 2'b00, 1'b1);
    wait_done("disable");
    check("off_en", 32'(hwpe_en), 32'b00);
    check("off_ready", 32'(req_ready), 32'd1);

    do_req(1'b1, 1'b0, 1'b1, 1, 2'b00, 0, 2'b00, 1'b1);
    wait_done("repeat_off");

    test_mode = 1'b1;
    #1;
    check("test_mode_en", 32'(hwpe_en), 32'b11);
    test_mode = 1'b0;
    #1;
    check("test_mode_release", 32'(hwpe_en), 32'b00);

    // Reset in the middle of CLEAR aborts the switch immediately.
    do_req(1'b0, 1'b1, 1'b0, 0, 2'b00, 0, 2'b00, 1'b0);
    tick();
    check("clear_pulse", 32'(hwpe_clear), 32'b01);
    check("clear_en", 32'(hwpe_en), 32'b01);
    check("clear_cfg_block", 32'(cfg_block), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid_clear");
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_err_cleared", 32'(err), 32'd0);

    do_req(1'b0, 1'b1, 1'b1, 4, 2'b01, 2, 2'b01, 1'b0);
    wait_done("recover_0");

`ifdef HWPE_SWITCH_TIMEOUT_EN
    // Busy stuck: watchdog forces GATE after 16 DRAIN cycles.
    hwpe_busy = 2'b01;
    do_req(1'b1, 1'b1, 1'b1, 20, 2'b10, 2, 2'b10, 1'b1);
    wait_done("timeout");
    hwpe_busy = 2'b00;
`endif

    check("sb_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
